// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use stall, redirect flush, mult/div hold.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_uses_rs,
  input  logic       i_uses_rt,
  input  logic       i_idex_mem_read,
  input  logic [4:0] i_idex_rt,
  input  logic       i_md_start,
  input  logic       i_md_done,
  input  logic       i_branch_taken,
  input  logic       i_jreg_taken,
  output logic       o_pc_write,
  output logic       o_ifid_write,
  output logic       o_ifid_flush,
  output logic       o_idex_write,
  output logic       o_idex_flush,
  output logic       o_md_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  // state      | meaning
  // ST_RUN     | normal issue; load-use stall and redirect flush handled here
  // ST_MDWAIT  | mult/div occupies EX; front end frozen, watchdog running
  // ST_MDDRAIN | bubble replaces the mult/div in ID/EX; ID instruction held
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MDWAIT  = 2'd1;
  localparam logic [1:0] ST_MDDRAIN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_md_cnt;
  logic             r_md_timeout;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_lu;
  logic w_rd;
  logic w_md_expire;
  logic w_md_enter;

  // Hazard terms are gated by reset so outputs sit at RUN defaults while reset is held.
  assign w_rs_hit    = i_uses_rs && (i_ifid_rs == i_idex_rt);
  assign w_rt_hit    = i_uses_rt && (i_ifid_rt == i_idex_rt);
  assign w_lu        = i_rst_n && i_idex_mem_read && (i_idex_rt != 5'd0) && (w_rs_hit || w_rt_hit);
  assign w_rd        = i_rst_n && (i_branch_taken || i_jreg_taken);
  assign w_md_expire = (r_md_cnt == CNT_LAST);
  assign w_md_enter  = i_rst_n && i_md_start && !w_rd;

  always_comb begin
    o_pc_write   = 1'b1;
    o_ifid_write = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_write = 1'b1;
    o_idex_flush = 1'b0;
    w_state_nxt  = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_rd) begin
          o_ifid_flush = 1'b1;
          o_idex_flush = 1'b1;
        end else if (w_lu) begin
          o_pc_write   = 1'b0;
          o_ifid_write = 1'b0;
          o_idex_flush = 1'b1;
        end
        if (w_md_enter) begin
          w_state_nxt = ST_MDWAIT;
        end
      end
      ST_MDWAIT: begin
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        o_idex_write = 1'b0;
        if (i_md_done || w_md_expire) begin
          w_state_nxt = ST_MDDRAIN;
        end
      end
      ST_MDDRAIN: begin
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        o_idex_flush = 1'b1;
        w_state_nxt  = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_md_cnt <= '0;
    end else if (r_state == ST_RUN && w_md_enter) begin
      r_md_cnt <= '0;
    end else if (r_state == ST_MDWAIT) begin
      r_md_cnt <= r_md_cnt + CNT_W'(1);
    end
  end

  // Sticky: only reset clears a watchdog expiry, so software can see it after the fact.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_md_timeout <= 1'b0;
    end else if (r_state == ST_MDWAIT && !i_md_done && w_md_expire) begin
      r_md_timeout <= 1'b1;
    end
  end

  assign o_md_timeout = r_md_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!o_pc_write) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (o_ifid_flush || o_idex_flush) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  // Without performance counters the controller carries no extra state.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_stall_ctrl;
  localparam int MDT = 8;
  localparam int CW  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic       uses_rs = 0, uses_rt = 0, mem_read = 0;
  logic       md_start = 0, md_done = 0, br = 0, jr = 0;
  logic       pc_w, ifid_w, ifid_f, idex_w, idex_f, md_to;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad = 0;

  bit          m_busy, m_drain, m_to;
  int          m_el;
  logic [31:0] m_sc, m_fc;

  hazard_stall_ctrl #(.MD_TIMEOUT(MDT), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt),
    .i_uses_rs(uses_rs), .i_uses_rt(uses_rt),
    .i_idex_mem_read(mem_read), .i_idex_rt(idex_rt),
    .i_md_start(md_start), .i_md_done(md_done),
    .i_branch_taken(br), .i_jreg_taken(jr),
    .o_pc_write(pc_w), .o_ifid_write(ifid_w), .o_ifid_flush(ifid_f),
    .o_idex_write(idex_w), .o_idex_flush(idex_f), .o_md_timeout(md_to)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    ifid_rs = 0; ifid_rt = 0; idex_rt = 0; uses_rs = 0; uses_rt = 0;
    mem_read = 0; md_start = 0; md_done = 0; br = 0; jr = 0;
  endtask

  // Called just after a falling edge with inputs already driven; checks, advances model, ends at next falling edge.
  task automatic step();
    bit lu, rd, e_pc, e_ifw, e_iff, e_idw, e_idf;
    #1;
    if (!rst_n) begin
      m_busy = 0; m_drain = 0; m_to = 0; m_el = 0; m_sc = 0; m_fc = 0;
    end
    lu = mem_read && (idex_rt != 0) &&
         ((uses_rs && ifid_rs == idex_rt) || (uses_rt && ifid_rt == idex_rt));
    rd = br || jr;
    e_pc = 1; e_ifw = 1; e_idw = 1; e_iff = 0; e_idf = 0;
    if (rst_n) begin
      if (m_drain) begin
        e_pc = 0; e_ifw = 0; e_idf = 1;
      end else if (m_busy) begin
        e_pc = 0; e_ifw = 0; e_idw = 0;
      end else if (rd) begin
        e_iff = 1; e_idf = 1;
      end else if (lu) begin
        e_pc = 0; e_ifw = 0; e_idf = 1;
      end
    end
    chk("pc_write",   32'(pc_w),   32'(e_pc));
    chk("ifid_write", 32'(ifid_w), 32'(e_ifw));
    chk("ifid_flush", 32'(ifid_f), 32'(e_iff));
    chk("idex_write", 32'(idex_w), 32'(e_idw));
    chk("idex_flush", 32'(idex_f), 32'(e_idf));
    chk("md_timeout", 32'(md_to),  32'(m_to));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
`endif
    if (rst_n) begin
      if (!e_pc) m_sc = m_sc + 32'd1;
      if (e_iff || e_idf) m_fc = m_fc + 32'd1;
      if (m_drain) begin
        m_drain = 0;
      end else if (m_busy) begin
        if (md_done || m_el == MDT - 1) begin
          if (!md_done) m_to = 1;
          m_busy = 0;
          m_drain = 1;
        end else begin
          m_el++;
        end
      end else if (md_start && !rd) begin
        m_busy = 1;
        m_el = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int stalls;
    bit back;
    @(negedge clk);
    // Reset held with a load-use and a branch on the inputs: outputs must stay at defaults.
    mem_read = 1; idex_rt = 5'd8; ifid_rs = 5'd8; uses_rs = 1; br = 1;
    #1;
    chk("rst_pc_write", 32'(pc_w), 32'd1);
    chk("rst_ifid_flush", 32'(ifid_f), 32'd0);
    chk("rst_md_timeout", 32'(md_to), 32'd0);
    step();
    rst_n = 1; clear_inputs();
    step();

    // Load-use: one stall cycle, then bubble releases it.
    mem_read = 1; idex_rt = 5'd8; ifid_rs = 5'd8; uses_rs = 1;
    #1 chk("lu_pc_write", 32'(pc_w), 32'd0);
    chk("lu_idex_flush", 32'(idex_f), 32'd1);
    step();
    mem_read = 0;
    #1 chk("lu_release_pc", 32'(pc_w), 32'd1);
    step();

    // Register 0 and unused Rt never stall.
    mem_read = 1; idex_rt = 0; ifid_rs = 0; uses_rs = 1;
    #1 chk("r0_no_stall", 32'(pc_w), 32'd1);
    step();
    idex_rt = 5'd5; ifid_rs = 5'd1; ifid_rt = 5'd5; uses_rs = 1; uses_rt = 0;
    #1 chk("nouse_no_stall", 32'(pc_w), 32'd1);
    step();

    // Redirect beats load-use.
    uses_rt = 1; br = 1;
    #1 chk("prio_pc_write", 32'(pc_w), 32'd1);
    chk("prio_ifid_flush", 32'(ifid_f), 32'd1);
    chk("prio_idex_flush", 32'(idex_f), 32'd1);
    step();
    clear_inputs();
    step();

    // Mult/div with done in the fifth wait cycle: 5 wait + 1 drain stalls.
    md_start = 1; md_done = 1;
    step();
    md_start = 0; md_done = 0;
    stalls = 0; back = 0;
    for (int k = 1; k <= 20 && !back; k++) begin
      md_done = (k == 5);
      #1;
      if (pc_w) back = 1; else stalls++;
      step();
    end
    md_done = 0;
    chk("md_back_to_run", 32'(back), 32'd1);
    chk("md_stall_cycles", 32'(stalls), 32'd6);
    chk("md_no_timeout", 32'(md_to), 32'd0);

    // Watchdog expiry: 8 wait + 1 drain stalls, sticky flag.
    md_start = 1;
    step();
    md_start = 0;
    stalls = 0; back = 0;
    for (int k = 1; k <= 30 && !back; k++) begin
      #1;
      if (pc_w) back = 1; else stalls++;
      step();
    end
    chk("wd_back_to_run", 32'(back), 32'd1);
    chk("wd_stall_cycles", 32'(stalls), 32'd9);
    chk("wd_timeout_set", 32'(md_to), 32'd1);
    repeat (3) step();
    chk("wd_timeout_sticky", 32'(md_to), 32'd1);

    // Reset in the middle of a mult/div wait.
    md_start = 1;
    step();
    md_start = 0;
    repeat (3) step();
    rst_n = 0; mem_read = 1; idex_rt = 5'd3; ifid_rs = 5'd3; uses_rs = 1;
    #1;
    chk("midrst_pc_write", 32'(pc_w), 32'd1);
    chk("midrst_ifid_write", 32'(ifid_w), 32'd1);
    chk("midrst_idex_write", 32'(idex_w), 32'd1);
    chk("midrst_idex_flush", 32'(idex_f), 32'd0);
    chk("midrst_md_timeout", 32'(md_to), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("midrst_stall_cnt", stall_cnt, 32'd0);
`endif
    step();
    rst_n = 1; clear_inputs();
    step();

    // Randomized traffic with small register pool to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      ifid_rs  = 5'($urandom_range(0, 3));
      ifid_rt  = 5'($urandom_range(0, 3));
      idex_rt  = 5'($urandom_range(0, 3));
      uses_rs  = 1'($urandom_range(0, 1));
      uses_rt  = 1'($urandom_range(0, 1));
      mem_read = ($urandom_range(0, 2) == 0);
      md_start = ($urandom_range(0, 9) == 0);
      md_done  = ($urandom_range(0, 5) == 0);
      br       = ($urandom_range(0, 7) == 0);
      jr       = ($urandom_range(0, 11) == 0);
      rst_n    = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
